// File: rtl/return_address_stack.sv
// return_address_stack: hardware call/return stack driving the program counter's data/load pair.
// Calls push pc_in+1 and jump to target; returns pop the top entry back into the counter.
module return_address_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         pc_in,
    input  logic [WIDTH-1:0]         target,
    input  logic                     call,
    input  logic                     ret,
    input  logic                     clear_err,
    output logic [WIDTH-1:0]         data,
    output logic                     load,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     conflict
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [AW:0]      depth_q, depth_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load_q, load_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             conflict_q, conflict_d;
    logic             call_only, ret_only, do_push, do_pop;
    logic [AW-1:0]    wr_idx, top_idx;

    assign full      = depth_q == CAP;
    assign empty     = depth_q == '0;
    assign call_only = call & ~ret;
    assign ret_only  = ret & ~call;
    assign do_push   = call_only & ~full;
    assign do_pop    = ret_only & ~empty;
    assign wr_idx    = depth_q[AW-1:0];
    assign top_idx   = AW'(depth_q - ONE);

    always_comb begin
        stack_d = stack_q;
        if (do_push) stack_d[wr_idx] = pc_in + WIDTH'(1);
        depth_d     = do_push ? depth_q + ONE : do_pop ? depth_q - ONE : depth_q;
        load_d      = call_only | do_pop;
        data_d      = call_only ? target : do_pop ? stack_q[top_idx] : data_q;
        // a new error event in the clearing cycle keeps the flag set
        overflow_d  = (overflow_q & ~clear_err) | (call_only & full);
        underflow_d = (underflow_q & ~clear_err) | (ret_only & empty);
        conflict_d  = (conflict_q & ~clear_err) | (call & ret);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stack_q     <= '{default: '0};
            depth_q     <= '0;
            data_q      <= '0;
            load_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            stack_q     <= stack_d;
            depth_q     <= depth_d;
            data_q      <= data_d;
            load_q      <= load_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            conflict_q  <= conflict_d;
        end
    end

    assign data      = data_q;
    assign load      = load_q;
    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign conflict  = conflict_q;
endmodule

// File: tb/tb_return_address_stack.sv
// tb_return_address_stack: directed scenarios plus randomized traffic against a queue-based LIFO model.
module tb_return_address_stack;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc_in = '0, target = '0;
    logic        call = 1'b0, ret = 1'b0, clear_err = 1'b0;
    logic [15:0] data;
    logic        load, full, empty, overflow, underflow, conflict;
    logic [3:0]  depth;
    int          errors = 0, checks = 0;

    logic [15:0] m_stk[$];
    logic [15:0] m_data;
    logic        m_load, m_ovf, m_unf, m_cnf;
    logic [25:0] obs;

    return_address_stack #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .target(target), .call(call), .ret(ret),
        .clear_err(clear_err), .data(data), .load(load), .depth(depth), .full(full),
        .empty(empty), .overflow(overflow), .underflow(underflow), .conflict(conflict)
    );

    always #5 clk = ~clk;

    assign obs = {data, load, depth, full, empty, overflow, underflow, conflict};

    function automatic logic [25:0] expv();
        int n = m_stk.size();
        return {m_data, m_load, 4'(n), n == 8, n == 0, m_ovf, m_unf, m_cnf};
    endfunction

    task automatic model_reset();
        m_stk.delete();
        m_data = '0; m_load = 0; m_ovf = 0; m_unf = 0; m_cnf = 0;
    endtask

    task automatic step(input logic c, input logic r, input logic [15:0] pc, input logic [15:0] t,
                        input logic clr);
        logic ev_o, ev_u, ev_c;
        call = c; ret = r; pc_in = pc; target = t; clear_err = clr;
        @(posedge clk);
        ev_o = 0; ev_u = 0; ev_c = 0; m_load = 0;
        if (c && r) ev_c = 1;
        else if (c) begin
            if (m_stk.size() < 8) m_stk.push_back(pc + 16'd1);
            else ev_o = 1;
            m_load = 1; m_data = t;
        end else if (r) begin
            if (m_stk.size() > 0) begin m_data = m_stk.pop_back(); m_load = 1; end
            else ev_u = 1;
        end
        m_ovf = (m_ovf & ~clr) | ev_o;
        m_unf = (m_unf & ~clr) | ev_u;
        m_cnf = (m_cnf & ~clr) | ev_c;
        #1;
        call = 0; ret = 0; clear_err = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #12;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 16'h1234, 16'h5678, 0);
            checks++;
            if (obs !== {16'h0, 1'b0, 4'd0, 1'b0, 1'b1, 3'b000}) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %h expected %h", i, obs, {16'h0, 1'b0, 4'd0, 1'b0, 1'b1, 3'b000});
            end
        end
    endtask

    task automatic test_call_ret();
        step(1, 0, 16'h0010, 16'h0200, 0);
        checks++;
        if ({load, data, depth} !== {1'b1, 16'h0200, 4'd1}) begin
            errors++; $display("FAIL call_load: got %b/%h/%0d expected 1/0200/1", load, data, depth);
        end
        step(0, 0, 16'h0000, 16'h0000, 0);
        checks++;
        if ({load, data, depth} !== {1'b0, 16'h0200, 4'd1}) begin
            errors++; $display("FAIL idle_hold: got %b/%h/%0d expected 0/0200/1", load, data, depth);
        end
        step(0, 1, 16'h0000, 16'h0000, 0);
        checks++;
        if ({load, data, depth} !== {1'b1, 16'h0011, 4'd0}) begin
            errors++; $display("FAIL ret_load: got %b/%h/%0d expected 1/0011/0", load, data, depth);
        end
    endtask

    task automatic test_overflow_underflow();
        for (int k = 0; k < 9; k++) begin
            step(1, 0, 16'(k), 16'h0300 + 16'(k), 0);
            checks++;
            if ({load, data, depth, full, overflow} !== {1'b1, 16'h0300 + 16'(k), 4'(k < 8 ? k + 1 : 8), k >= 7, k == 8}) begin
                errors++;
                $display("FAIL fill_call %0d: got load=%b data=%h depth=%0d full=%b ovf=%b", k, load, data, depth, full, overflow);
            end
        end
        for (int k = 0; k < 9; k++) begin
            step(0, 1, 16'h0000, 16'h0000, 0);
            checks++;
            if (k < 8 && {load, data, depth, underflow} !== {1'b1, 16'(8 - k), 4'(7 - k), 1'b0}) begin
                errors++;
                $display("FAIL drain_ret %0d: got load=%b data=%h depth=%0d unf=%b expected data=%h", k, load, data, depth, underflow, 16'(8 - k));
            end
            if (k == 8 && {load, depth, empty, underflow} !== {1'b0, 4'd0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL underflow_ret: got load=%b depth=%0d empty=%b unf=%b expected 0/0/1/1", load, depth, empty, underflow);
            end
        end
        step(0, 0, 16'h0000, 16'h0000, 1);
        checks++;
        if ({overflow, underflow, conflict} !== 3'b000) begin
            errors++; $display("FAIL clear_flags: got %b expected 000", {overflow, underflow, conflict});
        end
    endtask

    task automatic test_wrap();
        step(1, 0, 16'hFFFF, 16'h0400, 0);
        step(0, 1, 16'h0000, 16'h0000, 0);
        checks++;
        if ({load, data} !== {1'b1, 16'h0000}) begin
            errors++; $display("FAIL wrap_ret: got %b/%h expected 1/0000", load, data);
        end
    endtask

    task automatic test_conflict();
        step(1, 0, 16'h0100, 16'h0500, 0);
        step(1, 0, 16'h0101, 16'h0600, 0);
        step(1, 1, 16'h0102, 16'h0700, 0);
        checks++;
        if ({load, depth, conflict, data} !== {1'b0, 4'd2, 1'b1, 16'h0600}) begin
            errors++; $display("FAIL conflict: got load=%b depth=%0d cnf=%b data=%h expected 0/2/1/0600", load, depth, conflict, data);
        end
        step(1, 1, 16'h0000, 16'h0000, 1);
        checks++;
        if (conflict !== 1'b1) begin
            errors++; $display("FAIL clear_set_wins: got conflict=%b expected 1", conflict);
        end
        step(0, 0, 16'h0000, 16'h0000, 1);
        checks++;
        if ({conflict, depth} !== {1'b0, 4'd2}) begin
            errors++; $display("FAIL conflict_clear: got cnf=%b depth=%0d expected 0/2", conflict, depth);
        end
        step(0, 1, 16'h0000, 16'h0000, 0);
        checks++;
        if ({load, data} !== {1'b1, 16'h0102}) begin
            errors++; $display("FAIL pop_after_conflict: got %b/%h expected 1/0102", load, data);
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 16'h0020, 16'h0800, 0);
        step(1, 0, 16'h0021, 16'h0900, 0);
        step(1, 0, 16'h0022, 16'h0A00, 0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({load, depth, data, empty} !== {1'b0, 4'd0, 16'h0000, 1'b1}) begin
            errors++; $display("FAIL async_reset: got load=%b depth=%0d data=%h empty=%b expected 0/0/0000/1", load, depth, data, empty);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int r = int'($urandom_range(99));
            step(r < 45 || r >= 95, r >= 45 && r < 85 || r >= 95, 16'($urandom), 16'($urandom), $urandom_range(9) == 0);
            checks++;
            if (obs !== expv()) begin
                errors++; $display("FAIL random cycle %0d: got %h expected %h", i, obs, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_overflow_underflow();
        test_wrap();
        test_conflict();
        test_async_reset();
        do_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
